// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control sequencer: steps each instruction from FETCH to writeback, raising selects and strobes as it goes.
// Stalls in FETCH, MEMREAD or MEMWRITE until mem_ready; otherwise it advances one state per cycle.
module multicycle_control_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           imm_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [2:0]           alu_control,
  output logic                 instr_retired,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic                 illegal_instr
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state, state_nxt;
  logic [2:0] alu_dec;
  logic       alu_bad;
  logic       retire;
  logic       req_raw, irw_raw, pcw_raw, mw_raw, rw_raw;

  always_comb begin
    alu_dec = ALU_ADD;
    alu_bad = 1'b0;
    case (funct3)
      3'b000:  alu_dec = (op[5] & funct7) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    req_raw       = 1'b0;
    irw_raw       = 1'b0;
    pcw_raw       = 1'b0;
    mw_raw        = 1'b0;
    rw_raw        = 1'b0;
    retire        = 1'b0;
    adr_src       = 1'b0;
    imm_src       = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    alu_control   = ALU_ADD;
    illegal_instr = 1'b0;
    case (state)
      FETCH: begin
        req_raw    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        irw_raw    = mem_ready;
        pcw_raw    = mem_ready;
        if (mem_ready) state_nxt = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_STORE:  imm_src = 2'b01;
          OP_BRANCH: imm_src = 2'b10;
          OP_JAL:    imm_src = 2'b11;
          default:   imm_src = 2'b00;
        endcase
        case (op)
          OP_LOAD, OP_STORE: state_nxt = MEMADR;
          OP_RTYPE:          state_nxt = EXECR;
          OP_ITYPE:          state_nxt = EXECI;
          OP_BRANCH:         state_nxt = BRANCH;
          OP_JAL:            state_nxt = JAL;
          default:           state_nxt = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = op[5] ? 2'b01 : 2'b00;
        state_nxt = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        req_raw = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_nxt = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        rw_raw     = 1'b1;
        retire     = 1'b1;
        state_nxt  = FETCH;
      end
      MEMWRITE: begin
        req_raw = 1'b1;
        adr_src = 1'b1;
        mw_raw  = 1'b1;
        retire  = mem_ready;
        if (mem_ready) state_nxt = FETCH;
      end
      EXECR, EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = (state == EXECI) ? 2'b01 : 2'b00;
        alu_control = alu_dec;
        state_nxt   = alu_bad ? TRAP : ALUWB;
      end
      ALUWB: begin
        rw_raw    = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        case (funct3)
          3'b000:  begin pcw_raw = zero;  retire = 1'b1; state_nxt = FETCH; end
          3'b001:  begin pcw_raw = ~zero; retire = 1'b1; state_nxt = FETCH; end
          default: state_nxt = TRAP;
        endcase
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pcw_raw   = 1'b1;
        state_nxt = ALUWB;
      end
      TRAP:    illegal_instr = 1'b1;
      default: state_nxt = TRAP;
    endcase
  end

  // Strobes stay quiet for the whole reset assertion, not just after the first edge.
  assign mem_req       = req_raw & rst_n;
  assign ir_write      = irw_raw & rst_n;
  assign pc_write      = pcw_raw & rst_n;
  assign mem_write     = mw_raw  & rst_n;
  assign reg_write     = rw_raw  & rst_n;
  assign instr_retired = retire  & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FETCH;
      retired_count <= '0;
    end else begin
      state <= state_nxt;
      if (instr_retired) retired_count <= retired_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class cycle by cycle against hand-derived output signatures.
module tb_multicycle_control_fsm;
  logic        clk;
  logic        rst_n;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, adr_src, ir_write, pc_write, mem_write, reg_write;
  logic [1:0]  imm_src, alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_control;
  logic        instr_retired, illegal_instr;
  logic [31:0] retired_count;
  logic [18:0] obs;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          exp_cnt  = 0;

  multicycle_control_fsm #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .mem_write(mem_write),
    .reg_write(reg_write), .imm_src(imm_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_control(alu_control),
    .instr_retired(instr_retired), .retired_count(retired_count),
    .illegal_instr(illegal_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign obs = {mem_req, adr_src, ir_write, pc_write, mem_write, reg_write, imm_src,
                alu_src_a, alu_src_b, result_src, alu_control, instr_retired, illegal_instr};

  function automatic logic [18:0] e(input int mreq, input int adr, input int irw, input int pcw,
                                    input int mw, input int rw, input int imm, input int a,
                                    input int b, input int rs, input int alu, input int ret,
                                    input int ill);
    return {1'(mreq), 1'(adr), 1'(irw), 1'(pcw), 1'(mw), 1'(rw), 2'(imm),
            2'(a), 2'(b), 2'(rs), 3'(alu), 1'(ret), 1'(ill)};
  endfunction

  function automatic logic [18:0] s_fetch(input int r); return e(1,0,r,r,0,0,0,0,2,2,0,0,0); endfunction
  function automatic logic [18:0] s_dec(input int imm); return e(0,0,0,0,0,0,imm,1,1,0,0,0,0); endfunction
  function automatic logic [18:0] s_madr(input int imm); return e(0,0,0,0,0,0,imm,2,1,0,0,0,0); endfunction
  function automatic logic [18:0] s_mwr(input int r); return e(1,1,0,0,1,0,0,0,0,0,0,r,0); endfunction
  function automatic logic [18:0] s_exr(input int alu); return e(0,0,0,0,0,0,0,2,0,0,alu,0,0); endfunction
  function automatic logic [18:0] s_exi(input int alu); return e(0,0,0,0,0,0,0,2,1,0,alu,0,0); endfunction
  function automatic logic [18:0] s_br(input int pc); return e(0,0,0,pc,0,0,0,2,0,0,1,1,0); endfunction
  localparam logic [18:0] S_RST  = 19'({1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,2'b10,3'b000,1'b0,1'b0});
  localparam logic [18:0] S_MRD  = 19'({1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0});
  localparam logic [18:0] S_MWB  = 19'({1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b01,3'b000,1'b1,1'b0});
  localparam logic [18:0] S_AWB  = 19'({1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,3'b000,1'b1,1'b0});
  localparam logic [18:0] S_JAL  = 19'({1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,3'b000,1'b0,1'b0});
  localparam logic [18:0] S_TRAP = 19'd1;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] x);
    n_assert++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, x);
    end
  endtask

  // Inputs are set one time unit after a rising edge; outputs are sampled three units later.
  task automatic cyc(input string tag, input logic [18:0] x);
    #3;
    check(tag, 32'(obs), 32'(x));
    @(posedge clk);
    #1;
  endtask

  task automatic retired(input string tag);
    exp_cnt++;
    check(tag, retired_count, 32'(exp_cnt));
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; op = 7'd0; funct3 = 3'd0; funct7 = 1'b0; zero = 1'b0;
    #12;
    check("reset_outputs", 32'(obs), 32'(S_RST));
    check("reset_count", retired_count, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    op = 7'b0000011; funct3 = 3'b010;
    cyc("lw_fetch", s_fetch(1));
    check("cnt_after_reset", retired_count, 32'd0);
    cyc("lw_decode", s_dec(0));
    cyc("lw_memadr", s_madr(0));
    cyc("lw_memread", S_MRD);
    cyc("lw_memwb", S_MWB);
    retired("lw_count");

    op = 7'b0100011;
    cyc("sw_fetch", s_fetch(1));
    cyc("sw_decode", s_dec(1));
    cyc("sw_memadr", s_madr(1));
    mem_ready = 1'b0;
    cyc("sw_wait1", s_mwr(0));
    cyc("sw_wait2", s_mwr(0));
    mem_ready = 1'b1;
    cyc("sw_done", s_mwr(1));
    retired("sw_count");

    op = 7'b0110011; funct3 = 3'b000; funct7 = 1'b1; mem_ready = 1'b0;
    cyc("sub_fetch_stall", s_fetch(0));
    mem_ready = 1'b1;
    cyc("sub_fetch", s_fetch(1));
    cyc("sub_decode", s_dec(0));
    cyc("sub_execr", s_exr(1));
    cyc("sub_aluwb", S_AWB);
    retired("sub_count");

    funct7 = 1'b0;
    cyc("add_fetch", s_fetch(1));
    cyc("add_decode", s_dec(0));
    cyc("add_execr", s_exr(0));
    cyc("add_aluwb", S_AWB);
    retired("add_count");

    op = 7'b0010011; funct7 = 1'b1; funct3 = 3'b110;
    cyc("ori_fetch", s_fetch(1));
    cyc("ori_decode", s_dec(0));
    cyc("ori_execi", s_exi(3));
    cyc("ori_aluwb", S_AWB);
    retired("ori_count");

    funct3 = 3'b000;
    cyc("addi_fetch", s_fetch(1));
    cyc("addi_decode", s_dec(0));
    cyc("addi_execi", s_exi(0));
    cyc("addi_aluwb", S_AWB);
    retired("addi_count");

    op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    cyc("beq_t_fetch", s_fetch(1));
    cyc("beq_t_decode", s_dec(2));
    cyc("beq_t_branch", s_br(1));
    retired("beq_t_count");
    zero = 1'b0;
    cyc("beq_n_fetch", s_fetch(1));
    cyc("beq_n_decode", s_dec(2));
    cyc("beq_n_branch", s_br(0));
    retired("beq_n_count");
    funct3 = 3'b001;
    cyc("bne_fetch", s_fetch(1));
    cyc("bne_decode", s_dec(2));
    cyc("bne_branch", s_br(1));
    retired("bne_count");

    op = 7'b1101111;
    cyc("jal_fetch", s_fetch(1));
    cyc("jal_decode", s_dec(3));
    cyc("jal_jal", S_JAL);
    cyc("jal_aluwb", S_AWB);
    retired("jal_count");

    op = 7'b1111111;
    cyc("ill_fetch", s_fetch(1));
    cyc("ill_decode", s_dec(0));
    cyc("ill_trap1", S_TRAP);
    cyc("ill_trap2", S_TRAP);
    check("ill_no_retire", retired_count, 32'(exp_cnt));

    rst_n = 1'b0;
    #2;
    check("trap_reset_outputs", 32'(obs), 32'(S_RST));
    check("trap_reset_count", retired_count, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; exp_cnt = 0;

    op = 7'b0110011; funct3 = 3'b001;
    cyc("badf3_fetch", s_fetch(1));
    cyc("badf3_decode", s_dec(0));
    cyc("badf3_execr", s_exr(0));
    cyc("badf3_trap", S_TRAP);
    check("badf3_no_retire", retired_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
